// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: instruction width, NOP encoding,
// default boot address and the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    HOLD  = 3'd4
  } fetch_state_t;

endpackage : riscv_pkg

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit. Issues one aligned request at a
// time, holds the returned word for decode, and handles redirects that land
// while a request is in flight by discarding the stale response.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] redirect_pc_aligned;

  // The low two bits of a redirect target are never meaningful for a
  // 4-byte fetch, so they are forced to zero before loading pc.
  assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

  // Request and valid are suppressed combinationally in any cycle carrying a
  // redirect, so neither a stale fetch nor a stale instruction escapes.
  assign imem_req_valid = (state_q == FETCH) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == HOLD) && !redirect_valid;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;

  // Next-state, pc and output-register update for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc_aligned;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc_aligned;
          // A response in the redirect cycle is simply thrown away;
          // otherwise it is still owed and must be swallowed in DROP.
          state_d = imem_rsp_valid ? FETCH : DROP;
        end else if (imem_rsp_valid) begin
          if_instr_d = imem_rsp_data;
          if_pc_d    = pc_q;
          state_d    = HOLD;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_d = redirect_pc_aligned;
        end
        // Leaving on the discarded beat even when a redirect coincides keeps
        // the FSM from waiting for a response that will never come.
        if (imem_rsp_valid) begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc_aligned;
          state_d = FETCH;
        end else if (if_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pc and held-instruction registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected request addresses and
// decoded instructions are queued by each scenario and retired as the DUT
// produces handshakes, alongside a behavioural instruction memory.
module tb_instruction_fetch;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] BOOT = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } if_exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            if_valid;
  logic            if_ready = 1'b0;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  logic [63:0] addr_q[$];
  if_exp_t     if_q[$];

  int checks = 0;
  int errors = 0;

  // memory model state
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  logic [63:0] mem_addr = '0;
  bit          use_ovr = 0;
  logic [31:0] ovr_word = '0;
  bit          hs_seen = 0;

  instruction_fetch #(.XLEN(XLEN), .RESET_PC(BOOT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (use_ovr) return ovr_word;
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe handshakes at negedge, then advance memory after posedge.
  task automatic step();
    if_exp_t e;
    logic [63:0] a;
    @(negedge clk);
    hs_seen = 0;
    if (imem_req_valid && imem_req_ready) begin
      hs_seen = 1;
      check_eq("req_align", 64'(imem_req_addr[1:0]), 64'd0);
      if (addr_q.size() == 0) begin
        check_eq("req_unexpected", 64'(addr_q.size()), 64'd1);
      end else begin
        a = addr_q.pop_front();
        check_eq("req_addr", imem_req_addr, a);
      end
      mem_pend = 1;
      mem_cnt  = mem_lat;
      mem_addr = imem_req_addr;
    end
    if (if_valid && if_ready) begin
      if (if_q.size() == 0) begin
        check_eq("if_unexpected", 64'(if_q.size()), 64'd1);
      end else begin
        e = if_q.pop_front();
        check_eq("if_pc", if_pc, e.pc);
        check_eq("if_instr", 64'(if_instr), 64'(e.instr));
      end
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pend       = 0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic push_if(input logic [63:0] pc, input logic [31:0] instr);
    if_exp_t e;
    e.pc = pc;
    e.instr = instr;
    if_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    while ((addr_q.size() != 0 || if_q.size() != 0) && n < bound) begin
      step();
      n++;
    end
    imem_req_ready = 1'b0;
    check_eq({tag, "_left"}, 64'(addr_q.size() + if_q.size()), 64'd0);
    addr_q.delete();
    if_q.delete();
  endtask

  task automatic wait_hs(input string tag, input int bound);
    int n = 0;
    imem_req_ready = 1'b1;
    hs_seen = 0;
    while (!hs_seen && n < bound) begin
      step();
      n++;
    end
    imem_req_ready = 1'b0;
    check_eq({tag, "_hs"}, 64'(hs_seen), 64'd1);
  endtask

  initial begin
    logic [63:0] all_ones;
    int n;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check_eq("rst_if_valid", 64'(if_valid), 64'd0);
    check_eq("rst_if_instr", 64'(if_instr), 64'h13);
    check_eq("rst_if_pc", if_pc, 64'd0);
    rst_n = 1'b1;

    // back-to-back fetch, 1-cycle latency
    mem_lat = 1;
    addr_q.push_back(BOOT);
    addr_q.push_back(BOOT + 4);
    addr_q.push_back(BOOT + 8);
    push_if(BOOT,     mem_word(BOOT));
    push_if(BOOT + 4, mem_word(BOOT + 4));
    push_if(BOOT + 8, mem_word(BOOT + 8));
    drain("seq", 40);

    // decode stall in HOLD
    use_ovr = 1;
    ovr_word = 32'h0050_0093;
    addr_q.push_back(BOOT + 12);
    if_ready = 1'b0;
    imem_req_ready = 1'b1;
    n = 0;
    while (!if_valid && n < 20) begin
      step();
      n++;
    end
    imem_req_ready = 1'b0;
    check_eq("stall_reach_hold", 64'(if_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      imem_req_ready = 1'b1;
      step();
      check_eq("stall_if_valid", 64'(if_valid), 64'd1);
      check_eq("stall_if_instr", 64'(if_instr), 64'h0050_0093);
      check_eq("stall_if_pc", if_pc, BOOT + 12);
      check_eq("stall_no_req", 64'(imem_req_valid), 64'd0);
    end
    use_ovr = 0;
    push_if(BOOT + 12, 32'h0050_0093);
    addr_q.push_back(BOOT + 16);
    push_if(BOOT + 16, mem_word(BOOT + 16));
    drain("stall", 30);

    // redirect in WAIT, response two cycles later is dropped
    mem_lat = 2;
    if_ready = 1'b1;
    addr_q.push_back(BOOT + 20);
    wait_hs("wredir", 20);
    redirect_valid = 1'b1;
    redirect_pc = 64'h1002;
    step();
    redirect_valid = 1'b0;
    check_eq("wredir_no_ifv", 64'(if_valid), 64'd0);
    mem_lat = 1;
    addr_q.push_back(64'h1000);
    push_if(64'h1000, mem_word(64'h1000));
    drain("wredir", 30);

    // redirect coincident with the response in WAIT
    addr_q.push_back(64'h1004);
    wait_hs("samecyc", 20);
    check_eq("samecyc_rsp", 64'(imem_rsp_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    imem_req_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("samecyc_req_valid", 64'(imem_req_valid), 64'd1);
    check_eq("samecyc_req_addr", imem_req_addr, 64'h2000);
    addr_q.push_back(64'h2000);
    push_if(64'h2000, mem_word(64'h2000));
    drain("samecyc", 30);

    // pc wrap, with redirect low bits ignored
    all_ones = '1;
    redirect_valid = 1'b1;
    redirect_pc = all_ones;
    step();
    redirect_valid = 1'b0;
    addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    push_if(64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC));
    addr_q.push_back(64'h0);
    push_if(64'h0, mem_word(64'h0));
    drain("wrap", 40);

    // reset pulsed while a request is outstanding
    mem_lat = 3;
    addr_q.push_back(64'h4);
    wait_hs("midrst", 20);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    check_eq("midrst_if_valid", 64'(if_valid), 64'd0);
    check_eq("midrst_if_instr", 64'(if_instr), 64'h13);
    check_eq("midrst_if_pc", if_pc, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    mem_lat = 1;
    addr_q.push_back(BOOT);
    push_if(BOOT, mem_word(BOOT));
    drain("midrst", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch
